// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared state enum, winner codes and HEX digit helpers for the match sequencer
package tug_pkg;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RESTART = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;
  localparam logic [3:0] HEX_BLANK    = 4'hF;

  function automatic logic [3:0] winner_hex(input logic [1:0] w);
    case (w)
      WINNER_LEFT:  return 4'h1;
      WINNER_RIGHT: return 4'h2;
      default:      return HEX_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_sat_counter.sv
// rtl/score_sat_counter.sv - 3-bit score counter saturating at 7, clear wins over increment
module score_sat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] count
);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 3'd0;
    end else if (inc && (count_q != 3'd7)) begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - round/match sequencing around the tug-of-war core: scoring, result hold, restart pulse
module match_sequencer
  import tug_pkg::*;
#(
  parameter int HOLDOFF   = 1000,
  parameter int WIN_SCORE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done,
  input  logic [1:0] winner,
  input  logic       new_match,
  output logic       soft_reset,
  output logic       in_enable,
  output logic [2:0] score_left,
  output logic [2:0] score_right,
  output logic       match_over,
  output logic [3:0] round_hex
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);
  localparam logic [2:0]  WIN_Q     = 3'(WIN_SCORE);

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  win_q, win_d;
  logic        inc_left, inc_right, clr_scores, decided;
  logic        soft_reset_q, in_enable_q, match_over_q;
  logic [3:0]  round_hex_q;

  assign decided = (score_left >= WIN_Q) || (score_right >= WIN_Q);

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    inc_left   = 1'b0;
    inc_right  = 1'b0;
    clr_scores = 1'b0;
    case (state_q)
      ST_PLAY: begin
        // A round only counts once done has been seen low, so a done left over from the last round is ignored
        if (armed_q && done) begin
          win_d     = winner;
          inc_left  = (winner == WINNER_LEFT);
          inc_right = (winner == WINNER_RIGHT);
          armed_d   = 1'b0;
          cnt_d     = 16'd0;
          state_d   = ST_HOLD;
        end else if (!done) begin
          armed_d = 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HOLD_LAST) begin
          state_d = decided ? ST_OVER : ST_RESTART;
        end
      end
      ST_RESTART: begin
        armed_d = 1'b0;
        state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (new_match) begin
          clr_scores = 1'b1;
          state_d    = ST_RESTART;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      armed_q      <= 1'b0;
      cnt_q        <= 16'd0;
      win_q        <= 2'b00;
      soft_reset_q <= 1'b0;
      in_enable_q  <= 1'b1;
      match_over_q <= 1'b0;
      round_hex_q  <= HEX_BLANK;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      soft_reset_q <= (state_d == ST_RESTART);
      in_enable_q  <= (state_d == ST_PLAY);
      match_over_q <= (state_d == ST_OVER);
      round_hex_q  <= ((state_d == ST_HOLD) || (state_d == ST_OVER)) ? winner_hex(win_d) : HEX_BLANK;
    end
  end

  score_sat_counter u_score_left (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_left),
    .count (score_left)
  );

  score_sat_counter u_score_right (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_right),
    .count (score_right)
  );

  assign soft_reset = soft_reset_q;
  assign in_enable  = in_enable_q;
  assign match_over = match_over_q;
  assign round_hex  = round_hex_q;

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - self-checking bench for match_sequencer (HOLDOFF=4, WIN_SCORE=3 and WIN_SCORE=7)
module tb_match_sequencer;

  localparam int HOLD = 4;
  localparam int WINS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, done_a, new_match_a;
  logic [1:0] winner_a;
  logic       soft_reset_a, in_enable_a, match_over_a;
  logic [2:0] score_left_a, score_right_a;
  logic [3:0] round_hex_a;

  logic       reset_b, done_b, new_match_b;
  logic [1:0] winner_b;
  logic       soft_reset_b, in_enable_b, match_over_b;
  logic [2:0] score_left_b, score_right_b;
  logic [3:0] round_hex_b;

  int n_cmp = 0;
  int n_bad = 0;

  match_sequencer #(.HOLDOFF(HOLD), .WIN_SCORE(WINS)) dut_a (
    .clk(clk), .reset(reset_a), .done(done_a), .winner(winner_a), .new_match(new_match_a),
    .soft_reset(soft_reset_a), .in_enable(in_enable_a), .score_left(score_left_a),
    .score_right(score_right_a), .match_over(match_over_a), .round_hex(round_hex_a)
  );

  match_sequencer #(.HOLDOFF(HOLD), .WIN_SCORE(7)) dut_b (
    .clk(clk), .reset(reset_b), .done(done_b), .winner(winner_b), .new_match(new_match_b),
    .soft_reset(soft_reset_b), .in_enable(in_enable_b), .score_left(score_left_b),
    .score_right(score_right_b), .match_over(match_over_b), .round_hex(round_hex_b)
  );

  wire [12:0] obs_a = {soft_reset_a, in_enable_a, match_over_a, round_hex_a, score_left_a, score_right_a};

  function automatic logic [12:0] pk(logic s, logic e, logic m, logic [3:0] h, logic [2:0] l, logic [2:0] r);
    return {s, e, m, h, l, r};
  endfunction

  // Reference model: phase 0 playing, 1 showing result, 2 restarting, 3 match decided
  int         m_phase, m_left_cycles, m_sl, m_sr;
  bit         m_seen_low;
  logic [1:0] m_last;

  task automatic model_step(input logic rst, input logic d, input logic [1:0] w, input logic nm);
    if (rst) begin
      m_phase = 0; m_left_cycles = 0; m_sl = 0; m_sr = 0; m_seen_low = 0; m_last = 2'b00;
    end else if (m_phase == 0) begin
      if (m_seen_low && d) begin
        m_last = w;
        if (w == 2'b01) m_sl = (m_sl < 7) ? m_sl + 1 : 7;
        if (w == 2'b10) m_sr = (m_sr < 7) ? m_sr + 1 : 7;
        m_seen_low = 0;
        m_left_cycles = HOLD;
        m_phase = 1;
      end else if (!d) begin
        m_seen_low = 1;
      end
    end else if (m_phase == 1) begin
      m_left_cycles--;
      if (m_left_cycles == 0) m_phase = (m_sl >= WINS || m_sr >= WINS) ? 3 : 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
      m_seen_low = 0;
    end else if (nm) begin
      m_sl = 0; m_sr = 0; m_phase = 2;
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [3:0] h;
    h = 4'hF;
    if (m_phase == 1 || m_phase == 3) h = (m_last == 2'b01) ? 4'h1 : (m_last == 2'b10) ? 4'h2 : 4'hF;
    return pk(m_phase == 2, m_phase == 0, m_phase == 3, h, 3'(m_sl), 3'(m_sr));
  endfunction

  task automatic tick(input logic rst, input logic d, input logic [1:0] w, input logic nm);
    reset_a = rst; done_a = d; winner_a = w; new_match_a = nm;
    @(posedge clk);
    model_step(rst, d, w, nm);
    #1;
  endtask

  task automatic tick_b(input logic rst, input logic d, input logic [1:0] w, input logic nm);
    reset_b = rst; done_b = d; winner_b = w; new_match_b = nm;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 2'b01, 1);
    n_cmp++;
    if (obs_a !== pk(0, 1, 0, 4'hF, 0, 0)) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs_a, pk(0, 1, 0, 4'hF, 0, 0));
    end
  endtask

  task automatic test_first_win();
    tick(0, 0, 2'b00, 0);
    n_cmp++;
    if (obs_a !== pk(0, 1, 0, 4'hF, 0, 0)) begin
      n_bad++; $display("FAIL first_win_arm: got %h want %h", obs_a, pk(0, 1, 0, 4'hF, 0, 0));
    end
    for (int i = 0; i < HOLD; i++) begin
      tick(0, 1, 2'b10, 0);
      n_cmp++;
      if (obs_a !== pk(0, 0, 0, 4'h2, 0, 1)) begin
        n_bad++; $display("FAIL first_win_hold%0d: got %h want %h", i, obs_a, pk(0, 0, 0, 4'h2, 0, 1));
      end
    end
    tick(0, 1, 2'b10, 0);
    n_cmp++;
    if (obs_a !== pk(1, 0, 0, 4'hF, 0, 1)) begin
      n_bad++; $display("FAIL first_win_restart: got %h want %h", obs_a, pk(1, 0, 0, 4'hF, 0, 1));
    end
    tick(0, 1, 2'b10, 0);
    n_cmp++;
    if (obs_a !== pk(0, 1, 0, 4'hF, 0, 1)) begin
      n_bad++; $display("FAIL first_win_play: got %h want %h", obs_a, pk(0, 1, 0, 4'hF, 0, 1));
    end
  endtask

  task automatic test_stale_done();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 2'b01, 0);
      n_cmp++;
      if (obs_a !== pk(0, 1, 0, 4'hF, 0, 1)) begin
        n_bad++; $display("FAIL stale_done%0d: got %h want %h", i, obs_a, pk(0, 1, 0, 4'hF, 0, 1));
      end
    end
    tick(0, 0, 2'b00, 0);
    tick(0, 1, 2'b01, 0);
    n_cmp++;
    if (obs_a !== pk(0, 0, 0, 4'h1, 1, 1)) begin
      n_bad++; $display("FAIL rearmed_win: got %h want %h", obs_a, pk(0, 0, 0, 4'h1, 1, 1));
    end
    tick(0, 0, 2'b00, 1);
    n_cmp++;
    if (obs_a !== pk(0, 0, 0, 4'h1, 1, 1)) begin
      n_bad++; $display("FAIL new_match_in_hold: got %h want %h", obs_a, pk(0, 0, 0, 4'h1, 1, 1));
    end
    tick(0, 0, 2'b00, 0);
    tick(0, 0, 2'b00, 0);
    tick(0, 0, 2'b00, 0);
    tick(0, 0, 2'b00, 0);
    tick(0, 0, 2'b00, 1);
    n_cmp++;
    if (obs_a !== pk(0, 1, 0, 4'hF, 1, 1)) begin
      n_bad++; $display("FAIL new_match_in_play: got %h want %h", obs_a, pk(0, 1, 0, 4'hF, 1, 1));
    end
  endtask

  task automatic test_match_over();
    tick(1, 0, 2'b00, 0);
    for (int k = 1; k <= WINS; k++) begin
      tick(0, 0, 2'b00, 0);
      tick(0, 0, 2'b00, 0);
      tick(0, 1, 2'b01, 0);
      n_cmp++;
      if (obs_a !== pk(0, 0, 0, 4'h1, 3'(k), 0)) begin
        n_bad++; $display("FAIL over_round%0d_win: got %h want %h", k, obs_a, pk(0, 0, 0, 4'h1, 3'(k), 0));
      end
      for (int i = 1; i < HOLD; i++) tick(0, 0, 2'b00, 0);
      tick(0, 0, 2'b00, 0);
      if (k < WINS) begin
        n_cmp++;
        if (obs_a !== pk(1, 0, 0, 4'hF, 3'(k), 0)) begin
          n_bad++; $display("FAIL over_round%0d_restart: got %h want %h", k, obs_a, pk(1, 0, 0, 4'hF, 3'(k), 0));
        end
      end else begin
        n_cmp++;
        if (obs_a !== pk(0, 0, 1, 4'h1, 3, 0)) begin
          n_bad++; $display("FAIL over_entered: got %h want %h", obs_a, pk(0, 0, 1, 4'h1, 3, 0));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, i[0], (i < 2) ? 2'b01 : 2'b10, 0);
      n_cmp++;
      if (obs_a !== pk(0, 0, 1, 4'h1, 3, 0)) begin
        n_bad++; $display("FAIL over_frozen%0d: got %h want %h", i, obs_a, pk(0, 0, 1, 4'h1, 3, 0));
      end
    end
  endtask

  task automatic test_new_match();
    tick(0, 0, 2'b00, 1);
    n_cmp++;
    if (obs_a !== pk(1, 0, 0, 4'hF, 0, 0)) begin
      n_bad++; $display("FAIL new_match_restart: got %h want %h", obs_a, pk(1, 0, 0, 4'hF, 0, 0));
    end
    tick(0, 0, 2'b00, 0);
    n_cmp++;
    if (obs_a !== pk(0, 1, 0, 4'hF, 0, 0)) begin
      n_bad++; $display("FAIL new_match_play: got %h want %h", obs_a, pk(0, 1, 0, 4'hF, 0, 0));
    end
  endtask

  task automatic test_invalid_and_reset();
    tick(1, 0, 2'b00, 0);
    tick(0, 0, 2'b00, 0);
    tick(0, 1, 2'b10, 0);
    for (int i = 0; i < HOLD + 2; i++) tick(0, 0, 2'b00, 0);
    tick(0, 1, 2'b00, 0);
    n_cmp++;
    if (obs_a !== pk(0, 0, 0, 4'hF, 0, 1)) begin
      n_bad++; $display("FAIL invalid_hold: got %h want %h", obs_a, pk(0, 0, 0, 4'hF, 0, 1));
    end
    tick(0, 1, 2'b11, 0);
    n_cmp++;
    if (obs_a !== pk(0, 0, 0, 4'hF, 0, 1)) begin
      n_bad++; $display("FAIL invalid_hold2: got %h want %h", obs_a, pk(0, 0, 0, 4'hF, 0, 1));
    end
    tick(1, 1, 2'b01, 1);
    n_cmp++;
    if (obs_a !== pk(0, 1, 0, 4'hF, 0, 0)) begin
      n_bad++; $display("FAIL reset_mid_hold: got %h want %h", obs_a, pk(0, 1, 0, 4'hF, 0, 0));
    end
  endtask

  task automatic test_win7_saturate();
    tick_b(1, 0, 2'b00, 0);
    for (int k = 1; k <= 7; k++) begin
      tick_b(0, 0, 2'b00, 0);
      tick_b(0, 0, 2'b00, 0);
      tick_b(0, 1, 2'b01, 0);
      n_cmp++;
      if (score_left_b !== 3'(k)) begin
        n_bad++; $display("FAIL win7_score%0d: got %0d want %0d", k, score_left_b, k);
      end
      for (int i = 0; i < HOLD; i++) tick_b(0, 0, 2'b00, 0);
      n_cmp++;
      if ({soft_reset_b, match_over_b} !== ((k < 7) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL win7_end%0d: got %b want %b", k, {soft_reset_b, match_over_b}, (k < 7) ? 2'b10 : 2'b01);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick_b(0, i[0], 2'b01, 0);
      n_cmp++;
      if ({match_over_b, score_left_b, score_right_b} !== {1'b1, 3'd7, 3'd0}) begin
        n_bad++; $display("FAIL win7_nowrap%0d: got %b want %b", i, {match_over_b, score_left_b, score_right_b}, 7'b1111000);
      end
    end
    tick_b(1, 0, 2'b00, 0);
    n_cmp++;
    if ({match_over_b, in_enable_b, score_left_b, round_hex_b} !== {2'b01, 3'd0, 4'hF}) begin
      n_bad++; $display("FAIL win7_reset_in_over: got %b want %b", {match_over_b, in_enable_b, score_left_b, round_hex_b}, 9'b010001111);
    end
  endtask

  task automatic test_random();
    logic rst, d, nm;
    logic [1:0] w;
    tick(1, 0, 2'b00, 0);
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      d   = ($urandom_range(0, 2) != 0);
      w   = 2'($urandom_range(0, 3));
      nm  = ($urandom_range(0, 9) == 0);
      tick(rst, d, w, nm);
      n_cmp++;
      if (obs_a !== model_out()) begin
        n_bad++; $display("FAIL random_cycle%0d: got %h want %h", c, obs_a, model_out());
      end
    end
  endtask

  initial begin
    reset_a = 1'b1; done_a = 1'b0; winner_a = 2'b00; new_match_a = 1'b0;
    reset_b = 1'b1; done_b = 1'b0; winner_b = 2'b00; new_match_b = 1'b0;
    test_reset();
    test_first_win();
    test_stale_done();
    test_match_over();
    test_new_match();
    test_invalid_and_reset();
    test_win7_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 The block SHALL have parameter HOLDOFF, default 1000; clk_game cycles the round result is displayed before restart; legal 1..65535.
REQ-002 The block SHALL have parameter WIN_SCORE, default 7; round wins needed to take the match; legal 1..7.
REQ-003 The block SHALL have port clk, input, 1, the single clock (clk_game domain); all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high hard reset.
REQ-005 The block SHALL have port done, input, 1, round-finished level from the tug-of-war core.
REQ-006 The block SHALL have port winner, input, 2, from the core, where 01 means left/cyber, 10 means right/human, and 00/11 mean invalid.
REQ-007 The block SHALL have port new_match, input, 1, single-cycle request to start a new match.
REQ-008 The block SHALL have port soft_reset, output, 1, a one-cycle core restart pulse, OR-ed with reset at the core.
REQ-009 The block SHALL have port in_enable, output, 1; when 0, the top gates the core's in pulses to 00.
REQ-010 The block SHALL have ports score_left and score_right, output, 3 each, the current match scores.
REQ-011 The block SHALL have port match_over, output, 1, high while a match is decided.
REQ-012 The block SHALL have port round_hex, output, 4, the HEX0 digit value: 1 (left), 2 (right) or F (blank).

Function
REQ-013 The FSM SHALL have exactly four states: PLAY, HOLD, RESTART and OVER.
REQ-014 In PLAY: in_enable=1, soft_reset=0, round_hex=F, and an internal armed flag sets on any cycle with done=0.
REQ-015 On a PLAY cycle with armed=1 and done=1, the block SHALL latch winner, increment the matching score (visible next cycle), clear armed and the hold counter, and go to HOLD.
REQ-016 Invalid winner (00/11) SHALL still enter HOLD, with no score change and round_hex=F.
REQ-017 Score increments SHALL saturate at 7; score width is fixed at 3 bits.
REQ-018 In HOLD: in_enable=0, the counter increments each cycle, and round_hex shows the latched winner.
REQ-019 When the counter reaches HOLDOFF-1, the next state SHALL be OVER if either score is at least WIN_SCORE, else RESTART.
REQ-020 In RESTART: soft_reset=1 for exactly that one cycle, in_enable=0, and the next state is PLAY with armed=0.
REQ-021 In OVER: match_over=1, in_enable=0, soft_reset=0, round_hex holds the final winner, scores are frozen, and done is ignored.
REQ-022 new_match in OVER SHALL clear both scores and go to RESTART; in any other state new_match SHALL be ignored.
REQ-023 In PLAY, done already high on entry SHALL NOT score again until done has been seen low (armed rule), which guards against a stale done after restart.
REQ-024 match_over SHALL be 1 only in OVER.
REQ-025 All outputs SHALL be registered or decoded from state/registers only, with no combinational path from inputs.

Reset
REQ-026 reset SHALL override all other inputs in the same cycle, including mid-HOLD and in OVER.
REQ-027 Reset values SHALL be: state=PLAY, armed=0, counter=0, scores=0, latched winner=00, soft_reset=0, in_enable=1, match_over=0, round_hex=F.

Structure
REQ-028 A shared package tug_pkg SHALL hold the state enum, WINNER_LEFT=2'b01, WINNER_RIGHT=2'b10, and HEX_BLANK=4'hF.
REQ-029 One sub-module score_sat_counter SHALL be used, instantiated twice: 3-bit, inc and clr inputs, saturating at 7, clr having priority over inc.
REQ-030 The hold counter SHALL be 16 bits and inline in the block.

Verification (bench uses HOLDOFF=4, WIN_SCORE=3)
REQ-031 Reset, then done=1 with winner=10 (armed): score_right=1 next cycle, round_hex=2, in_enable=0 for 4 cycles, then one soft_reset cycle, then PLAY.
REQ-032 done held high across RESTART and into PLAY: no second increment until done has dropped and re-risen.
REQ-033 Three left wins: after the third HOLD, match_over=1, score_left=3, no soft_reset pulse; further done pulses leave scores unchanged.
REQ-034 new_match in OVER: scores go to 0, a one-cycle soft_reset, then PLAY; new_match during PLAY or HOLD produces no change.
REQ-035 winner=00 with done: HOLD with round_hex=F and both scores unchanged; reset asserted mid-HOLD returns all outputs to reset values next cycle.
REQ-036 WIN_SCORE=7 variant: after 7 wins score_left=7, match_over=1, and the score does not wrap.
